issue_rat_freelist_ckpt: RTL
============================

Name: issue_rat_freelist_ckpt

Overview:
Parametrised PRF free list with in-order speculation checkpoints, the next-generation free list behind the issue-stage RAT. It holds free physical register indices in a circular FIFO, grants up to ACQ_N of them per cycle to rename, and accepts one redeemed PRF per cycle from retire. Each checkpoint snapshots the FIFO read pointer and is identified by an FGR tag. Abandoning an FGR rolls the read pointer back, which returns every PRF acquired after that checkpoint in one cycle.

Parameters:
PRF_COUNT, 64, number of physical registers; power of 2; FIFO depth
PRF_W, 6, log2(PRF_COUNT)
ARCH_REGS, 32, PRFs 0..ARCH_REGS-1 are mapped at reset and are not free
ACQ_N, 2, acquire lanes per cycle (1..4)
FGR_COUNT, 8, checkpoint slots; power of 2
FGR_W, 3, log2(FGR_COUNT)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
i_redeemed_prf  in  PRF_W  PRF returned to the free list
i_redeemed_valid  in  1  redeem request
o_redeemed_ready  out  1  redeem accept
o_acquire_prf  out  ACQ_N*PRF_W  lane k occupies bits [k*PRF_W +: PRF_W]
o_acquire_valid  out  ACQ_N  per-lane PRF available
i_acquire_ready  in  ACQ_N  per-lane take; must be contiguous from lane 0
o_ckpt_fgr  out  FGR_W  FGR tag allocated on a ckpt handshake
o_ckpt_ready  out  1  checkpoint slot available
i_ckpt_valid  in  1  allocate a checkpoint
i_commit_fgr  in  FGR_W  FGR being committed; must equal the oldest live checkpoint
i_commit_valid  in  1  release the oldest checkpoint
i_abandon_fgr  in  FGR_W  FGR to roll back to
i_abandon_valid  in  1  rollback request
o_free_count  out  PRF_W+1  current free PRFs

Behaviour:
- State:
  - FIFO mem[PRF_COUNT] of PRF_W bits.
  - rptr and wptr, each PRF_W+1 bits including a wrap bit.
  - Checkpoint ring: snap[FGR_COUNT] read-pointer snapshots, ck_head, ck_tail (FGR_W+1 bits each).
- Reset (reset==0, async):
  - mem[i] = ARCH_REGS+i for i < PRF_COUNT-ARCH_REGS.
  - rptr = 0, wptr = PRF_COUNT-ARCH_REGS.
  - Ring empty, ck_head = ck_tail = 0.
  - While reset is asserted, all outputs are 0. The first cycle after release gives o_free_count = 32.
- free_count = wptr - rptr, modulo 2^(PRF_W+1). o_free_count is registered-state based (no same-cycle bypass).
- Acquire:
  - o_acquire_valid[k] = (free_count > k) && !i_abandon_valid.
  - o_acquire_prf lane k = mem[(rptr+k) mod PRF_COUNT].
  - Fired lanes n = count of valid&ready, contiguous from lane 0. rptr += n at the clock edge.
  - Non-contiguous ready is illegal; the bench asserts on it.
- Redeem:
  - o_redeemed_ready = (free_count < PRF_COUNT).
  - On fire: mem[wptr] = i_redeemed_prf, wptr += 1.
  - The new entry is visible to acquire the next cycle; there is no bypass, even when free_count == 0.
- Checkpoint allocate:
  - o_ckpt_ready = (ring not full) && !i_abandon_valid.
  - o_ckpt_fgr = ck_tail[FGR_W-1:0].
  - On fire: snap[tail] = rptr + n, i.e. it includes this cycle's acquires, which belong to older instructions. Then ck_tail += 1.
- Commit: ck_head += 1. Commit on an empty ring, or with i_commit_fgr != ck_head, is illegal (assert).
- Abandon F:
  - rptr = snap[F] and ck_tail = F, so F and all younger checkpoints are discarded.
  - Same-cycle acquires are blocked, because valid is forced low.
  - A same-cycle redeem still writes, and wptr still advances.
  - F must be live. Abandon of the FGR being committed in the same cycle is illegal.
- Simultaneous events:
  - Commit plus allocate, and commit plus abandon of a younger F, both apply independently.
  - Ring full plus commit in the same cycle: ready stays 0 that cycle (no bypass).
- Upstream guarantee: PRFs acquired after a live checkpoint are not redeemed before it commits. Therefore wptr never overruns snap[ck_head], and rollback never reads overwritten entries.
- Pointer wrap: natural modulo 2^(PRF_W+1). Full is wptr-rptr == PRF_COUNT; empty is wptr == rptr.
- Latency: acquire is 0-cycle combinational from state; every state update takes 1 cycle.

Test Plan:
1. Release reset, hold ready=2'b11 for 16 cycles -> PRFs 32,33 then 34,35 ... 62,63 granted; then valid=0; o_free_count=0.
2. From empty, redeem PRF 5 in cycle t -> o_acquire_valid[0]=0 in t, =1 with prf 5 in t+1; o_free_count=1.
3. After reset: ckpt alloc (fgr 0), acquire 6 PRFs (32..37), abandon fgr 0 -> next cycle lane 0 gives 32 again; o_free_count=32; o_ckpt_ready=1.
4. Allocate 8 checkpoints -> o_ckpt_ready=0 with fgr 0..7 issued; commit fgr 0 -> ready=1 next cycle, o_ckpt_fgr=0 (ring wraps).
5. Same cycle: abandon fgr 2 (ckpts 0..4 live), redeem PRF 7, lane-0 ready -> no acquire; redeem accepted; ck_tail=2; checkpoints 0 and 1 remain live.
6. Assert reset mid-burst with free_count=10 and 3 live checkpoints -> outputs 0 immediately; after release the state equals power-on: free 32, ring empty.

Source files
------------

// File: rtl/issue_rat_freelist_ckpt.sv
// PRF free list: circular FIFO of free physical registers with a ring of
// read-pointer checkpoints that allow single-cycle rollback of speculative acquires.
module issue_rat_freelist_ckpt #(
  parameter int PRF_COUNT = 64,
  parameter int PRF_W     = 6,
  parameter int ARCH_REGS = 32,
  parameter int ACQ_N     = 2,
  parameter int FGR_COUNT = 8,
  parameter int FGR_W     = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [PRF_W-1:0]       i_redeemed_prf,
  input  logic                   i_redeemed_valid,
  output logic                   o_redeemed_ready,
  output logic [ACQ_N*PRF_W-1:0] o_acquire_prf,
  output logic [ACQ_N-1:0]       o_acquire_valid,
  input  logic [ACQ_N-1:0]       i_acquire_ready,
  output logic [FGR_W-1:0]       o_ckpt_fgr,
  output logic                   o_ckpt_ready,
  input  logic                   i_ckpt_valid,
  input  logic [FGR_W-1:0]       i_commit_fgr,
  input  logic                   i_commit_valid,
  input  logic [FGR_W-1:0]       i_abandon_fgr,
  input  logic                   i_abandon_valid,
  output logic [PRF_W:0]         o_free_count
);
  localparam int FREE_INIT = PRF_COUNT - ARCH_REGS;

  logic [PRF_W-1:0] r_mem [PRF_COUNT];
  logic [PRF_W:0]   r_rptr;
  logic [PRF_W:0]   r_wptr;
  logic [PRF_W:0]   r_snap [FGR_COUNT];
  logic [FGR_W:0]   r_ck_head;
  logic [FGR_W:0]   r_ck_tail;

  logic [PRF_W:0]         w_free;
  logic [ACQ_N-1:0]       w_acq_valid;
  logic [ACQ_N*PRF_W-1:0] w_acq_prf;
  logic [PRF_W:0]         w_n;
  logic                   w_contig;
  logic                   w_red_ready;
  logic                   w_red_fire;
  logic [FGR_W:0]         w_ck_used;
  logic                   w_ck_ready;
  logic                   w_ck_fire;
  logic [FGR_W:0]         w_ab_tail;
  logic [PRF_W:0]         w_rptr_adv;

  assign w_free = r_wptr - r_rptr;

  // Grant lanes from the FIFO head; only a contiguous run from lane 0 fires.
  always_comb begin
    w_acq_valid = '0;
    w_acq_prf   = '0;
    w_n         = '0;
    w_contig    = 1'b1;
    for (int k = 0; k < ACQ_N; k++) begin
      w_acq_valid[k] = (w_free > (PRF_W+1)'(k)) && !i_abandon_valid;
      w_acq_prf[k*PRF_W +: PRF_W] = r_mem[r_rptr[PRF_W-1:0] + PRF_W'(k)];
      if (w_contig && w_acq_valid[k] && i_acquire_ready[k])
        w_n = w_n + (PRF_W+1)'(1);
      else
        w_contig = 1'b0;
    end
  end

  assign w_rptr_adv  = r_rptr + w_n;
  assign w_red_ready = (w_free < (PRF_W+1)'(PRF_COUNT));
  assign w_red_fire  = i_redeemed_valid && w_red_ready;
  assign w_ck_used   = r_ck_tail - r_ck_head;
  assign w_ck_ready  = (w_ck_used != (FGR_W+1)'(FGR_COUNT)) && !i_abandon_valid;
  assign w_ck_fire   = i_ckpt_valid && w_ck_ready;
  // Rebuild the wrap bit of the abandoned tag from its distance past the head.
  assign w_ab_tail   = r_ck_head + {1'b0, FGR_W'(i_abandon_fgr - r_ck_head[FGR_W-1:0])};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < PRF_COUNT; i++)
        r_mem[i] <= (i < FREE_INIT) ? PRF_W'(ARCH_REGS + i) : '0;
      for (int i = 0; i < FGR_COUNT; i++)
        r_snap[i] <= '0;
      r_rptr    <= '0;
      r_wptr    <= (PRF_W+1)'(FREE_INIT);
      r_ck_head <= '0;
      r_ck_tail <= '0;
    end else begin
      if (w_red_fire) begin
        r_mem[r_wptr[PRF_W-1:0]] <= i_redeemed_prf;
        r_wptr                   <= r_wptr + (PRF_W+1)'(1);
      end
      if (i_abandon_valid) begin
        r_rptr    <= r_snap[i_abandon_fgr];
        r_ck_tail <= w_ab_tail;
      end else begin
        r_rptr <= w_rptr_adv;
        if (w_ck_fire) begin
          r_snap[r_ck_tail[FGR_W-1:0]] <= w_rptr_adv;
          r_ck_tail                    <= r_ck_tail + (FGR_W+1)'(1);
        end
      end
      if (i_commit_valid)
        r_ck_head <= r_ck_head + (FGR_W+1)'(1);
    end
  end

  assign o_acquire_valid  = reset ? w_acq_valid : '0;
  assign o_acquire_prf    = reset ? w_acq_prf : '0;
  assign o_redeemed_ready = reset && w_red_ready;
  assign o_ckpt_ready     = reset && w_ck_ready;
  assign o_ckpt_fgr       = reset ? r_ck_tail[FGR_W-1:0] : '0;
  assign o_free_count     = reset ? w_free : '0;
endmodule
